// File: rtl/alu_pkg.sv
// Shared ALU types: operand/operation encodings, the ALU input bundle, and the
// result/state types used by the ALU sharing controller.
package alu_pkg;

    typedef logic [7:0] data;

    typedef enum logic [2:0] {
        ADD         = 3'd0,
        SUB         = 3'd1,
        MUL         = 3'd2,
        DIV         = 3'd3,
        LEFT_SHIFT  = 3'd4,
        RIGHT_SHIFT = 3'd5
    } operation;

    typedef enum logic {
        UNSIGN = 1'b0,
        SIGN   = 1'b1
    } mode;

    typedef union packed {
        logic signed [7:0] s;
        logic        [7:0] u;
    } alu_value_t;

    typedef struct packed {
        logic       clock;
        operation   alu_op;
        mode        alu_mode;
        alu_value_t value1;
        alu_value_t value2;
    } input_to_alu;

    typedef struct packed {
        data  res;
        logic c_out;
        logic overflow;
        logic zero;
    } alu_result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant from a valid vector and a priority pointer.
// With ALU_SHARE_FIXED_PRI_EN defined, requester 0 always wins and the pointer rotates over 1..NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_grant,
    output logic [$clog2(NUM_REQ)-1:0] next_ptr
);

    localparam int IW = $clog2(NUM_REQ);

    int idx_v;
    int nxt_v;

    // search from the pointer with wrap; first valid requester wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        next_ptr  = ptr;
        idx_v     = 0;
        nxt_v     = 0;
`ifdef ALU_SHARE_FIXED_PRI_EN
        if (valid[0]) begin
            grant[0]  = 1'b1;
            any_grant = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ - 1; i++) begin
                // index 0 is never part of the rotation
                idx_v = ((ptr == '0) ? 1 : int'(ptr)) + i;
                if (idx_v >= NUM_REQ) begin
                    idx_v = idx_v - (NUM_REQ - 1);
                end else begin
                    idx_v = idx_v;
                end
                if (!any_grant && valid[idx_v]) begin
                    grant[idx_v] = 1'b1;
                    grant_idx    = IW'(idx_v);
                    any_grant    = 1'b1;
                    nxt_v        = (idx_v + 1 >= NUM_REQ) ? 1 : idx_v + 1;
                    next_ptr     = IW'(nxt_v);
                end else begin
                    any_grant = any_grant;
                end
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = int'(ptr) + i;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!any_grant && valid[idx_v]) begin
                grant[idx_v] = 1'b1;
                grant_idx    = IW'(idx_v);
                any_grant    = 1'b1;
                nxt_v        = (idx_v + 1 >= NUM_REQ) ? 0 : idx_v + 1;
                next_ptr     = IW'(nxt_v);
            end else begin
                any_grant = any_grant;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 8-bit ALU among NUM_REQ requesters: arbitrates, issues, waits ALU_LATENCY, returns result.
// Optional build macro ALU_SHARE_FIXED_PRI_EN gives requester 0 fixed top priority (handled in rr_arbiter).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  operation                   req_op   [NUM_REQ],
    input  mode                        req_mode [NUM_REQ],
    input  data                        req_a    [NUM_REQ],
    input  data                        req_b    [NUM_REQ],
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output data                        rsp_data,
    output logic                       rsp_c_out,
    output logic                       rsp_overflow,
    output logic                       rsp_zero,
    output input_to_alu                alu_in,
    input  data                        alu_out,
    input  logic                       alu_c_out,
    input  logic                       alu_overflow,
    input  logic                       alu_zero
);

    localparam int IW = $clog2(NUM_REQ);

    ctrl_state_t        state_r;
    logic [IW-1:0]      ptr_r;
    logic [2:0]         cnt_r;
    operation           op_r;
    mode                mode_r;
    alu_value_t         value1_r;
    alu_value_t         value2_r;
    alu_result_t        rsp_r;
    logic               rsp_valid_r;
    logic [IW-1:0]      rsp_id_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      next_ptr_s;
    logic               any_s;
    logic               div0_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (win_idx_s),
        .any_grant (any_s),
        .next_ptr  (next_ptr_s)
    );

    // acceptance is only possible while idle and out of reset
    always_comb begin
        req_ready = '0;
        div0_s    = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            req_ready = grant_s;
            div0_s    = (req_op[win_idx_s] == DIV) && (req_b[win_idx_s] == 8'h00);
        end else begin
            req_ready = '0;
        end
    end

    // sequencer: accept, hold operands for the ALU latency, then present the response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            cnt_r       <= 3'd0;
            op_r        <= ADD;
            mode_r      <= UNSIGN;
            value1_r    <= 8'h00;
            value2_r    <= 8'h00;
            rsp_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        ptr_r    <= next_ptr_s;
                        rsp_id_r <= win_idx_s;
                        if (div0_s) begin
                            // divide by zero never reaches the ALU; alu_in keeps its last issue
                            rsp_r.res      <= 8'h00;
                            rsp_r.c_out    <= 1'b0;
                            rsp_r.overflow <= 1'b1;
                            rsp_r.zero     <= 1'b1;
                            rsp_valid_r    <= 1'b1;
                            state_r        <= RESP;
                        end else begin
                            op_r   <= req_op[win_idx_s];
                            mode_r <= req_mode[win_idx_s];
                            if (req_mode[win_idx_s] == SIGN) begin
                                value1_r.s <= signed'(req_a[win_idx_s]);
                                value2_r.s <= signed'(req_b[win_idx_s]);
                            end else begin
                                value1_r.u <= req_a[win_idx_s];
                                value2_r.u <= req_b[win_idx_s];
                            end
                            cnt_r   <= 3'(ALU_LATENCY);
                            state_r <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        rsp_r.res      <= alu_out;
                        rsp_r.c_out    <= alu_c_out;
                        rsp_r.overflow <= alu_overflow;
                        rsp_r.zero     <= alu_zero;
                        rsp_valid_r    <= 1'b1;
                        state_r        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // drive the ALU bundle and response channel from held registers
    always_comb begin
        alu_in.clock    = clock;
        alu_in.alu_op   = op_r;
        alu_in.alu_mode = mode_r;
        alu_in.value1   = value1_r;
        alu_in.value2   = value2_r;
        rsp_valid       = rsp_valid_r;
        rsp_id          = rsp_id_r;
        rsp_data        = rsp_r.res;
        rsp_c_out       = rsp_r.c_out;
        rsp_overflow    = rsp_r.overflow;
        rsp_zero        = rsp_r.zero;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (NUM_REQ=4, ALU_LATENCY=1) with a combinational ALU model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int LAT = 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    operation       req_op   [N];
    mode            req_mode [N];
    data            req_a    [N];
    data            req_b    [N];
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    data            rsp_data;
    logic           rsp_c_out, rsp_overflow, rsp_zero;
    input_to_alu    alu_in;
    data            alu_out;
    logic           alu_c_out, alu_overflow, alu_zero;
    logic [8:0]     wide;
    logic [15:0]    prod;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_share_ctrl #(.NUM_REQ(N), .ALU_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_c_out(rsp_c_out), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .alu_in(alu_in), .alu_out(alu_out), .alu_c_out(alu_c_out),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // single-cycle ALU model: result is visible in the same cycle the operands are
    always_comb begin
        wide = 9'h000; prod = 16'h0000;
        alu_out = 8'h00; alu_c_out = 1'b0; alu_overflow = 1'b0;
        case (alu_in.alu_op)
            ADD: begin
                wide = {1'b0, alu_in.value1.u} + {1'b0, alu_in.value2.u};
                alu_out = wide[7:0]; alu_c_out = wide[8];
                alu_overflow = (alu_in.value1.u[7] == alu_in.value2.u[7]) && (wide[7] != alu_in.value1.u[7]);
            end
            SUB: begin
                wide = {1'b0, alu_in.value1.u} - {1'b0, alu_in.value2.u};
                alu_out = wide[7:0]; alu_c_out = wide[8];
                alu_overflow = (alu_in.value1.u[7] != alu_in.value2.u[7]) && (wide[7] != alu_in.value1.u[7]);
            end
            MUL: begin
                prod = alu_in.value1.u * alu_in.value2.u;
                alu_out = prod[7:0]; alu_c_out = |prod[15:8]; alu_overflow = |prod[15:8];
            end
            DIV: alu_out = (alu_in.value2.u != 8'h00) ? alu_in.value1.u / alu_in.value2.u : 8'h00;
            LEFT_SHIFT: begin alu_out = alu_in.value1.u << 1; alu_c_out = alu_in.value1.u[7]; end
            RIGHT_SHIFT: begin alu_out = alu_in.value1.u >> 1; alu_c_out = alu_in.value1.u[0]; end
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic set_req(input int i, input operation op, input mode md, input data a, input data b);
        req_op[i] = op; req_mode[i] = md; req_a[i] = a; req_b[i] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, ADD, UNSIGN, 8'h00, 8'h00);
        do_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if ({rsp_id, rsp_data, rsp_c_out, rsp_overflow, rsp_zero} !== 13'h0) begin bad++;
            $display("FAIL reset_rsp got id=%0d data=%h flags=%b%b%b exp all zero", rsp_id, rsp_data, rsp_c_out, rsp_overflow, rsp_zero); end
        total++; if (alu_in.alu_op !== ADD || alu_in.alu_mode !== UNSIGN || alu_in.value1.u !== 8'h00 || alu_in.value2.u !== 8'h00) begin bad++;
            $display("FAIL reset_alu_in got op=%0d mode=%0d v1=%h v2=%h exp ADD UNSIGN 00 00", alu_in.alu_op, alu_in.alu_mode, alu_in.value1.u, alu_in.value2.u); end
    endtask

    task automatic test_add();
        int n;
        set_req(2, ADD, UNSIGN, 8'h8A, 8'h4A);
        req_valid = 4'b0100; #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL add_grant got=%b exp=0100", req_ready); end
        tick(); req_valid = '0; n = 1;
        total++; if (alu_in.value1.u !== 8'h8A || alu_in.value2.u !== 8'h4A || alu_in.alu_op !== ADD) begin bad++;
            $display("FAIL add_alu_in got v1=%h v2=%h op=%0d exp 8a 4a ADD", alu_in.value1.u, alu_in.value2.u, alu_in.alu_op); end
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n != LAT + 1) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", n, LAT + 1); end
        total++; if (rsp_id !== 2'd2 || rsp_data !== 8'hD4 || {rsp_c_out, rsp_overflow, rsp_zero} !== 3'b000) begin bad++;
            $display("FAIL add_rsp got id=%0d data=%h cvz=%b%b%b exp 2 d4 000", rsp_id, rsp_data, rsp_c_out, rsp_overflow, rsp_zero); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_clear got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_sub();
        int n;
        set_req(0, SUB, SIGN, 8'h8A, 8'h4A);
        req_valid = 4'b0001;
        tick(); req_valid = '0; n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (rsp_id !== 2'd0 || rsp_data !== 8'h40 || rsp_overflow !== 1'b1 || rsp_zero !== 1'b0) begin bad++;
            $display("FAIL sub_rsp got id=%0d data=%h ov=%b z=%b exp 0 40 1 0", rsp_id, rsp_data, rsp_overflow, rsp_zero); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        set_req(2, ADD, SIGN, 8'h11, 8'h22);
        req_valid = 4'b0100; tick(); req_valid = '0;
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || alu_in.value1.u !== 8'h00 || alu_in.alu_mode !== UNSIGN) begin bad++;
            $display("FAIL busy_reset got vld=%b data=%h id=%0d v1=%h mode=%0d exp 0 00 0 00 UNSIGN", rsp_valid, rsp_data, rsp_id, alu_in.value1.u, alu_in.alu_mode); end
        tick(); tick(); tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL busy_reset_no_rsp got=%b exp=0", rsp_valid); end
        req_valid = 4'b1111; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL busy_reset_first_grant got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int n, exp_id, gid, prev;
        logic [3:0] exp_grant;
        data exp_data;
        do_reset();
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, ADD, UNSIGN, 8'h10 + 8'(i), 8'h01);
            set_req(1, ADD, UNSIGN, 8'h20 + 8'(i), 8'h01);
            req_valid = 4'b0011; #1;
`ifdef ALU_SHARE_FIXED_PRI_EN
            exp_id = 0;
`else
            exp_id = i % 2;
`endif
            exp_grant = 4'b0001 << exp_id;
            gid = (req_ready == 4'b0010) ? 1 : 0;
            total++; if (req_ready !== exp_grant) begin bad++; $display("FAIL b2b_grant op=%0d got=%b exp=%b", i, req_ready, exp_grant); end
            tick();
            if (i > 0) begin
                total++; if (cyc - prev != LAT + 2) begin bad++; $display("FAIL b2b_throughput op=%0d got=%0d exp=%0d", i, cyc - prev, LAT + 2); end
            end
            prev = cyc; n = 1;
            while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
            exp_data = (exp_id == 0) ? 8'h11 + 8'(i) : 8'h21 + 8'(i);
            total++; if (rsp_id !== 2'(exp_id) || rsp_data !== exp_data || n >= 20) begin bad++;
                $display("FAIL b2b_rsp op=%0d grant=%0d got id=%0d data=%h exp id=%0d data=%h", i, gid, rsp_id, rsp_data, exp_id, exp_data); end
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        int n;
        set_req(3, MUL, UNSIGN, 8'h05, 8'h03);
        set_req(1, LEFT_SHIFT, UNSIGN, 8'h81, 8'h00);
        req_valid = 4'b1000; tick();
        req_valid = 4'b0010; n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h0F || {rsp_c_out, rsp_overflow, rsp_zero} !== 3'b000) begin bad++;
                $display("FAIL hold_rsp cyc=%0d got vld=%b id=%0d data=%h cvz=%b%b%b exp 1 3 0f 000", k, rsp_valid, rsp_id, rsp_data, rsp_c_out, rsp_overflow, rsp_zero); end
            total++; if (req_ready !== 4'b0000 || alu_in.alu_op !== MUL || alu_in.value1.u !== 8'h05) begin bad++;
                $display("FAIL hold_no_issue cyc=%0d got ready=%b op=%0d v1=%h exp 0000 MUL 05", k, req_ready, alu_in.alu_op, alu_in.value1.u); end
            tick();
        end
        req_valid = '0; rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_div0();
        set_req(1, DIV, UNSIGN, 8'h37, 8'h00);
        req_valid = 4'b0010; #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL div0_grant got=%b exp=0010", req_ready); end
        tick(); req_valid = '0;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h00 || {rsp_c_out, rsp_overflow, rsp_zero} !== 3'b011) begin bad++;
            $display("FAIL div0_rsp got vld=%b id=%0d data=%h cvz=%b%b%b exp 1 1 00 011", rsp_valid, rsp_id, rsp_data, rsp_c_out, rsp_overflow, rsp_zero); end
        total++; if (alu_in.alu_op !== MUL || alu_in.value1.u !== 8'h05 || alu_in.value2.u !== 8'h03) begin bad++;
            $display("FAIL div0_alu_in got op=%0d v1=%h v2=%h exp MUL 05 03", alu_in.alu_op, alu_in.value1.u, alu_in.value2.u); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL div0_clear got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_reset_mid_busy();
        test_back_to_back();
        test_hold();
        test_div0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
